usb_fs_in_rr_arb: RTL and testbench

// Registered round-robin arbiter sharing the IN protocol engine's single data path among
// NUM_IN_EPS IN endpoints. Locks a grant for the whole of one endpoint's request, rotates

---
 rtl/usb_fs_in_rr_arb.sv | 119 +++++++++++
 tb/tb_usb_fs_in_rr_arb.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/usb_fs_in_rr_arb.sv
// Round-robin arbiter sharing the IN protocol engine data path among IN endpoints.
// A grant is locked for one whole request, rotates on release and can be forced off by a hold timeout.
module usb_fs_in_rr_arb #(
    parameter int NUM_IN_EPS   = 1,
    parameter int GAP_CYCLES   = 1,
    parameter int HOLD_TIMEOUT = 0,
    localparam int IDX_W       = (NUM_IN_EPS > 1) ? $clog2(NUM_IN_EPS) : 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NUM_IN_EPS-1:0]   in_ep_req,
    input  logic [NUM_IN_EPS*8-1:0] in_ep_data,
    output logic [NUM_IN_EPS-1:0]   in_ep_grant,
    output logic [7:0]              arb_in_ep_data,
    output logic                    arb_busy,
    output logic [IDX_W-1:0]        arb_grant_idx,
    output logic                    timeout_evt
);

    localparam int CNT_W = (HOLD_TIMEOUT > 0) ? $clog2(HOLD_TIMEOUT + 1) : 1;
    localparam int GAP_W = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
    localparam logic [IDX_W-1:0] LAST_RST = IDX_W'(NUM_IN_EPS - 1);

    typedef enum logic [1:0] {
        IDLE,
        GRANT,
        GAP
    } state_t;

    state_t           state;
    logic [IDX_W-1:0] last_idx;
    logic [CNT_W-1:0] hold_cnt;
    logic [GAP_W-1:0] gap_cnt;

    logic [IDX_W-1:0] win_idx;
    logic             win_found;
    logic             gnt_req;
    logic             other_req;
    logic             to_hit;

    // Scan starts just after the last winner, so the released endpoint ranks lowest.
    always_comb begin
        win_idx   = last_idx;
        win_found = 1'b0;
        for (int unsigned k = 1; k <= NUM_IN_EPS; k++) begin
            logic [IDX_W-1:0] cand;
            cand = IDX_W'((32'(last_idx) + k) % NUM_IN_EPS);
            if (!win_found && in_ep_req[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    always_comb begin
        gnt_req   = |(in_ep_req & in_ep_grant);
        other_req = |(in_ep_req & ~in_ep_grant);
        to_hit    = (HOLD_TIMEOUT > 0) && (32'(hold_cnt) + 1 == HOLD_TIMEOUT) && other_req;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            in_ep_grant <= '0;
            last_idx    <= LAST_RST;
            hold_cnt    <= '0;
            gap_cnt     <= '0;
            timeout_evt <= 1'b0;
        end else begin
            timeout_evt <= 1'b0;
            case (state)
                IDLE: begin
                    if (win_found) begin
                        in_ep_grant <= NUM_IN_EPS'(1) << win_idx;
                        last_idx    <= win_idx;
                        hold_cnt    <= '0;
                        state       <= GRANT;
                    end
                end
                GRANT: begin
                    // A request drop wins over a coincident timeout: plain release, no event.
                    if (!gnt_req) begin
                        in_ep_grant <= '0;
                        gap_cnt     <= '0;
                        state       <= (GAP_CYCLES > 0) ? GAP : IDLE;
                    end else if (to_hit) begin
                        in_ep_grant <= '0;
                        gap_cnt     <= '0;
                        timeout_evt <= 1'b1;
                        state       <= (GAP_CYCLES > 0) ? GAP : IDLE;
                    end else if (32'(hold_cnt) < HOLD_TIMEOUT) begin
                        hold_cnt <= hold_cnt + CNT_W'(1);
                    end
                end
                GAP: begin
                    if (32'(gap_cnt) + 1 >= GAP_CYCLES) begin
                        state <= IDLE;
                    end else begin
                        gap_cnt <= gap_cnt + GAP_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        arb_in_ep_data = '0;
        for (int unsigned i = 0; i < NUM_IN_EPS; i++) begin
            if (in_ep_grant[i]) begin
                arb_in_ep_data = arb_in_ep_data | in_ep_data[8*i +: 8];
            end
        end
    end

    assign arb_busy      = (state != IDLE);
    assign arb_grant_idx = last_idx;

endmodule

// File: tb/tb_usb_fs_in_rr_arb.sv
// Bench for usb_fs_in_rr_arb: cycle model feeding a scoreboard plus directed scenario checks.
module tb_usb_fs_in_rr_arb;

    localparam int HT = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  req;
    logic [31:0] data = 32'hD4C3B2A1;
    logic [3:0]  grant;
    logic [7:0]  dout;
    logic        busy;
    logic [1:0]  idx;
    logic        tevt;

    logic [0:0]  req1;
    logic [7:0]  data1 = 8'h5A;
    logic [0:0]  grant1;
    logic [7:0]  dout1;
    logic        busy1;
    logic [0:0]  idx1;
    logic        tevt1;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    usb_fs_in_rr_arb #(.NUM_IN_EPS(4), .GAP_CYCLES(1), .HOLD_TIMEOUT(HT)) u_dut (
        .clk(clk), .reset(reset), .in_ep_req(req), .in_ep_data(data),
        .in_ep_grant(grant), .arb_in_ep_data(dout), .arb_busy(busy),
        .arb_grant_idx(idx), .timeout_evt(tevt)
    );

    usb_fs_in_rr_arb #(.NUM_IN_EPS(1), .GAP_CYCLES(0), .HOLD_TIMEOUT(0)) u_one (
        .clk(clk), .reset(reset), .in_ep_req(req1), .in_ep_data(data1),
        .in_ep_grant(grant1), .arb_in_ep_data(dout1), .arb_busy(busy1),
        .arb_grant_idx(idx1), .timeout_evt(tevt1)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [7:0] exp_byte(input logic [3:0] g);
        exp_byte = 8'h00;
        for (int i = 0; i < 4; i++) if (g[i]) exp_byte = data[8*i +: 8];
    endfunction

    // Behavioural model of the 4-endpoint instance; one expectation per clock edge.
    typedef struct {
        logic [3:0] gnt;
        logic [1:0] idx;
        logic       busy;
        logic       tevt;
    } exp_t;

    exp_t       sb_q[$];
    int         m_state;
    int         m_last;
    int         m_cnt;
    logic [3:0] m_gnt;
    logic       m_tevt;

    always @(posedge clk) begin
        m_tevt = 1'b0;
        if (reset) begin
            m_state = 0; m_gnt = '0; m_last = 3; m_cnt = 0;
        end else begin
            case (m_state)
                0: if (req != 4'b0000) begin
                    for (int k = 1; k <= 4; k++) begin
                        if (req[(m_last + k) % 4]) begin
                            m_last = (m_last + k) % 4;
                            break;
                        end
                    end
                    m_gnt = 4'b0001 << m_last; m_cnt = 0; m_state = 1;
                end
                1: if (!req[m_last]) begin
                    m_gnt = '0; m_state = 2;
                end else if (m_cnt == HT - 1 && (req & ~m_gnt) != 4'b0000) begin
                    m_gnt = '0; m_tevt = 1'b1; m_state = 2;
                end else if (m_cnt < HT) begin
                    m_cnt++;
                end
                default: m_state = 0;
            endcase
        end
        sb_q.push_back('{m_gnt, 2'(m_last), (m_state != 0), m_tevt});
    end

    always @(negedge clk) begin
        if (sb_q.size() > 0) begin
            exp_t e;
            e = sb_q.pop_front();
            check("sb_grant", 32'(grant), 32'(e.gnt));
            check("sb_idx",   32'(idx),   32'(e.idx));
            check("sb_busy",  32'(busy),  32'(e.busy));
            check("sb_tevt",  32'(tevt),  32'(e.tevt));
            check("sb_data",  32'(dout),  32'(exp_byte(e.gnt)));
        end
    end

    task automatic do_reset();
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired got=running exp=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int zeros, n0, nev, evt_at, first1, exp_i;
        reset = 1'b1; req = '0; req1 = '0;
        repeat (3) @(negedge clk);
        check("rst_grant", 32'(grant), 0);
        check("rst_idx",   32'(idx),   3);
        check("rst_busy",  32'(busy),  0);
        check("rst_tevt",  32'(tevt),  0);
        check("rst_data",  32'(dout),  0);
        check("one_rst_grant", 32'(grant1), 0);
        check("one_rst_idx",   32'(idx1),   0);
        reset = 1'b0;

        // Lock/release with a queued requester; single-endpoint gate alongside.
        req = 4'b0101; req1 = 1'b1;
        @(negedge clk);
        check("s1_grant0", 32'(grant), 32'b0001);
        check("one_grant", 32'(grant1), 1);
        check("one_data",  32'(dout1),  32'h5A);
        req1 = 1'b0;
        @(negedge clk);
        check("one_drop",  32'(grant1), 0);
        check("one_idle",  32'(busy1),  0);
        req1 = 1'b1;
        @(negedge clk);
        check("one_regrant", 32'(grant1), 1);
        check("one_idx",     32'(idx1),   0);
        check("s1_hold",     32'(grant),  32'b0001);
        req = 4'b0100; req1 = 1'b0;
        @(negedge clk);
        check("s1_drop",      32'(grant), 0);
        check("s1_drop_busy", 32'(busy),  1);
        @(negedge clk);
        check("s1_idle",      32'(grant), 0);
        check("s1_idle_busy", 32'(busy),  0);
        @(negedge clk);
        check("s1_next",     32'(grant), 32'b0100);
        check("s1_next_idx", 32'(idx),   2);
        check("s1_next_dat", 32'(dout),  32'hC3);
        req = '0;
        repeat (3) @(negedge clk);

        // Strict rotation with every endpoint requesting.
        do_reset();
        req = 4'b1111;
        for (int g = 0; g < 5; g++) begin
            exp_i = g % 4;
            zeros = 0;
            @(negedge clk);
            while (grant == 4'b0000 && zeros < 20) begin
                zeros++;
                if (zeros == 1) req = 4'b1111;
                @(negedge clk);
            end
            check("rr_idx",   32'(idx),   exp_i);
            check("rr_grant", 32'(grant), 32'(4'b0001 << exp_i));
            if (g > 0) check("rr_gap", zeros, 2);
            repeat (2) @(negedge clk);
            req[exp_i] = 1'b0;
        end
        req = '0;
        repeat (4) @(negedge clk);

        // Forced rotation by hold timeout.
        do_reset();
        req = 4'b0011;
        n0 = 0; nev = 0; evt_at = -1; first1 = -1;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            if (grant == 4'b0001) n0++;
            if (tevt) begin nev++; evt_at = i; end
            if (grant == 4'b0010 && first1 < 0) first1 = i;
        end
        check("to_hold_cycles", n0, HT);
        check("to_evt_count",   nev, 1);
        check("to_evt_cycle",   evt_at, HT + 1);
        check("to_next_grant",  first1, HT + 3);
        req = '0;
        repeat (4) @(negedge clk);

        // Lone requester is never timed out.
        req = 4'b0001;
        n0 = 0; nev = 0;
        repeat (20) begin
            @(negedge clk);
            if (grant == 4'b0001) n0++;
            if (tevt) nev++;
        end
        check("solo_hold", n0, 20);
        check("solo_evt",  nev, 0);
        req = '0;
        repeat (4) @(negedge clk);

        // Data mux on EP1 and with no grant.
        req = 4'b0010;
        @(negedge clk);
        check("dat_ep1",     32'(dout), 32'hB2);
        check("dat_ep1_idx", 32'(idx),  1);
        req = '0;
        repeat (3) @(negedge clk);
        check("dat_none", 32'(dout), 0);

        // Reset in the middle of a grant.
        req = 4'b0100;
        @(negedge clk);
        check("mr_grant", 32'(grant), 32'b0100);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("mr_grant0", 32'(grant), 0);
        check("mr_busy",   32'(busy),  0);
        check("mr_tevt",   32'(tevt),  0);
        check("mr_idx",    32'(idx),   3);
        reset = 1'b0;
        req = 4'b0110;
        @(negedge clk);
        check("mr_after",     32'(grant), 32'b0010);
        check("mr_after_idx", 32'(idx),   1);
        req = '0;
        repeat (3) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
